m_logmul_antilog: RTL and testbench
===================================

# m_logmul_antilog

Pipelined log-domain multiplier that sits directly downstream of the range-mapping stage. It accepts two 32-bit log words of the form {k[4:0], f[26:0]}, adds them, and converts the sum back to the linear domain with a Mitchell antilog. The result is a 64-bit approximate product. A valid/ready handshake on both sides and a 3-stage pipeline let it accept one operand pair per cycle when not back-pressured.

## Interface
Parameters:
- wl_L, 32, log word width ({k, f})
- wl_k, 5, characteristic width
- wl_f, 27, fraction width (wl_L - wl_k)
- wl_P, 64, linear product width
- wl_T, 8, sideband tag width

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operand pair present
- IN_READY  output  1  stage accepts operand pair this cycle
- A  input  wl_L  log word of operand A
- B  input  wl_L  log word of operand B
- A_ZERO  input  1  operand A is linear zero (log undefined)
- B_ZERO  input  1  operand B is linear zero
- IN_TAG  input  wl_T  sideband tag, carried unchanged
- OUT_VALID  output  1  product present
- OUT_READY  input  1  consumer accepts product
- P  output  wl_P  linear product
- P_ZERO  output  1  product forced to zero
- OUT_TAG  output  wl_T  tag of this product

## Operation
- Log word value: k + f/2^27, with k = L[31:27] and f = L[26:0].
- Stage 1 (S1): register A, B, zero flags and tag on accept.
- Stage 2 (S2): S = {0,A} + {0,B}, 33 bits, with no overflow possible. k_sum = S[32:27] (0..63), f_sum = S[26:0]. zero = A_ZERO | B_ZERO.
- Stage 3 (S3): M = {1, f_sum} (28 bits). P = (M << k_sum) >> 27 using a 91-bit intermediate, truncated and never rounded. The result always fits in 64 bits.
  - If zero is set, P = 0 and P_ZERO = 1.
- Each stage holds a valid bit.
- advance = ~v3 | OUT_READY. When advance is high, every stage shifts by one and S1 loads the input (v1 <= IN_VALID).
- IN_READY = advance, combinational from OUT_READY and v3.
- Transfer rules:
  - An input transfer happens on IN_VALID & IN_READY.
  - An output transfer happens on OUT_VALID & OUT_READY.
  - Bubbles are not compressed; whole-pipe stall only.
- The producer must hold A, B, flags and tag stable while IN_VALID is high and IN_READY is low.
- Reset mid-operation: all in-flight data is discarded and all valid bits clear immediately (asynchronous).

## Timing
- Latency: 3 cycles from input transfer to OUT_VALID, with no stalls.
- Throughput: 1 pair per cycle while OUT_READY stays high.
- Reset values: OUT_VALID = 0, P = 0, P_ZERO = 0, OUT_TAG = 0, all internal valid bits 0. IN_READY = 1 during and after reset, because v3 = 0.
- While OUT_READY is low with v3 = 1:
  - P, P_ZERO and OUT_TAG hold stable.
  - IN_READY = 0.
  - No stage changes.
- OUT_READY rising in the same cycle as a new IN_VALID: the output transfer and the input accept both occur on that edge.
- Release of RST takes effect on the first CLK edge after deassertion. Deassertion must be synchronised to CLK at the top level.

## Structure
- Shared package m_logmul_pkg holds wl_L, wl_k, wl_f, wl_P, wl_T and the field-slice constants (K_MSB = 31, K_LSB = 27, F_MSB = 26). The range-mapping side imports the same constants so the log word format has a single definition.
- One sub-module, m_antilog_shifter: combinational {k_sum, f_sum} -> P, instantiated in S3.
- The pipeline control stays in the top module.

## Test plan
- A = 32'h1800_0000 (log 8), B = 32'h1000_0000 (log 4), OUT_READY = 1 -> P = 64'd32 after 3 cycles, P_ZERO = 0, tag echoed.
- A = B = 32'h0C00_0000 (k = 1, f = 0.5) -> fraction carry gives k_sum = 3, f_sum = 0, so P = 64'd8.
- A = B = 32'hFFFF_FFFF -> k_sum = 63, f_sum = 27'h7FF_FFFE, so P = 64'hFFFF_FFE0_0000_0000 with no overflow.
- A_ZERO = 1 with A = 32'h1800_0000, B = 32'h1000_0000 -> P = 0, P_ZERO = 1.
- Stream 10 pairs with tags 0..9 while toggling OUT_READY pseudo-randomly. Required: outputs arrive in order with no loss or duplication, P stays stable during stalls, and IN_READY = 0 exactly when v3 & ~OUT_READY.
- Assert RST with 3 items in flight -> OUT_VALID drops at once. After release, the next input appears 3 cycles after acceptance, and no stale item is ever output.

Source files
------------

// File: rtl/m_logmul_pkg.sv
// Shared log-word format constants for the range-mapping and log-multiply stages.
// A log word is {k, f}: integer characteristic k and a 27-bit binary fraction f.
package m_logmul_pkg;
    localparam int wl_L = 32;
    localparam int wl_k = 5;
    localparam int wl_f = wl_L - wl_k;
    localparam int wl_P = 64;
    localparam int wl_T = 8;

    localparam int K_MSB = 31;
    localparam int K_LSB = 27;
    localparam int F_MSB = 26;

    // Shift workspace: 28-bit mantissa shifted by up to 63 places.
    localparam int wl_W = wl_f + 1 + 63;

    typedef logic [wl_L-1:0] log_word_t;
    typedef logic [wl_P-1:0] lin_word_t;
    typedef logic [wl_T-1:0] tag_t;
endpackage

// File: rtl/m_logmul_antilog_if.sv
// Operand/product handshake bundle for m_logmul_antilog.
// Valid/ready: a word moves on a rising edge where VALID & READY; the sender holds
// its payload stable while VALID is high and READY is low.
interface m_logmul_antilog_if;
    import m_logmul_pkg::*;

    logic      IN_VALID;
    logic      IN_READY;
    log_word_t A;
    log_word_t B;
    logic      A_ZERO;
    logic      B_ZERO;
    tag_t      IN_TAG;
    logic      OUT_VALID;
    logic      OUT_READY;
    lin_word_t P;
    logic      P_ZERO;
    tag_t      OUT_TAG;

    modport master (
        output IN_VALID, A, B, A_ZERO, B_ZERO, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, P, P_ZERO, OUT_TAG
    );

    modport slave (
        input  IN_VALID, A, B, A_ZERO, B_ZERO, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, P, P_ZERO, OUT_TAG
    );
endinterface

// File: rtl/m_antilog_shifter.sv
// Mitchell antilog: 2^(k_sum + f_sum/2^27) ~= {1, f_sum} << k_sum >> 27, truncated.
module m_antilog_shifter
    import m_logmul_pkg::*;
(
    input  logic [wl_k:0]   k_sum,
    input  logic [wl_f-1:0] f_sum,
    output lin_word_t       p
);
    logic [wl_W-1:0] mant;

    assign mant = {{(wl_W-wl_f-1){1'b0}}, 1'b1, f_sum};
    // With k_sum <= 63 the shifted value is below 2^91, so after >>27 it fits 64 bits.
    assign p = wl_P'((mant << k_sum) >> wl_f);
endmodule

// File: rtl/m_logmul_antilog.sv
// Three-stage log-domain multiplier: register operands, add log words, antilog.
// Whole-pipe stall: every stage advances together when the output slot is free.
module m_logmul_antilog
    import m_logmul_pkg::*;
(
    input logic CLK,
    input logic RST,
    m_logmul_antilog_if.slave bus
);
    logic      v1, v2, v3;
    log_word_t a1, b1;
    logic      az1, bz1;
    tag_t      tag1, tag2, tag3;
    logic [wl_L:0] sum2;
    logic      zero2;
    lin_word_t p3;
    logic      pz3;
    lin_word_t shift_p;
    logic      advance;

    assign advance = ~v3 | bus.OUT_READY;

    m_antilog_shifter u_shifter (
        .k_sum (sum2[wl_L:K_LSB]),
        .f_sum (sum2[F_MSB:0]),
        .p     (shift_p)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            az1   <= 1'b0;
            bz1   <= 1'b0;
            tag1  <= '0;
            sum2  <= '0;
            zero2 <= 1'b0;
            tag2  <= '0;
            p3    <= '0;
            pz3   <= 1'b0;
            tag3  <= '0;
        end else if (advance) begin
            v1 <= bus.IN_VALID;
            v2 <= v1;
            v3 <= v2;
            // Payload registers only load behind a valid bit so bubbles do not disturb P.
            if (bus.IN_VALID) begin
                a1   <= bus.A;
                b1   <= bus.B;
                az1  <= bus.A_ZERO;
                bz1  <= bus.B_ZERO;
                tag1 <= bus.IN_TAG;
            end
            if (v1) begin
                sum2  <= {1'b0, a1} + {1'b0, b1};
                zero2 <= az1 | bz1;
                tag2  <= tag1;
            end
            if (v2) begin
                p3   <= zero2 ? '0 : shift_p;
                pz3  <= zero2;
                tag3 <= tag2;
            end
        end
    end

    assign bus.IN_READY  = advance;
    assign bus.OUT_VALID = v3;
    assign bus.P         = p3;
    assign bus.P_ZERO    = pz3;
    assign bus.OUT_TAG   = tag3;
endmodule

// File: tb/tb_m_logmul_antilog.sv
// Directed bench for m_logmul_antilog: reset, single products, streaming with
// back-pressure, back-to-back throughput and reset with items in flight.
module tb_m_logmul_antilog;
    import m_logmul_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [wl_T+wl_P-1:0] exp_q[$];

    m_logmul_antilog_if bus ();

    m_logmul_antilog dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        az;
        logic        bz;
        logic [7:0]  tag;
        logic [63:0] p;
        logic        pz;
    } vec_t;

    task automatic idle_inputs();
        bus.IN_VALID = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.A_ZERO = 1'b0;
        bus.B_ZERO = 1'b0;
        bus.IN_TAG = '0;
    endtask

    task automatic drain();
        idle_inputs();
        bus.OUT_READY = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    // Starts at a negedge; returns edges from accept to OUT_VALID and the product seen.
    task automatic send_one(input vec_t v, output int lat, output logic [63:0] p,
                            output logic pz, output logic [7:0] t);
        bus.A = v.a;
        bus.B = v.b;
        bus.A_ZERO = v.az;
        bus.B_ZERO = v.bz;
        bus.IN_TAG = v.tag;
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        lat = 1;
        while (!bus.OUT_VALID && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        p = bus.P;
        pz = bus.P_ZERO;
        t = bus.OUT_TAG;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.OUT_READY = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.P !== 64'd0 || bus.P_ZERO !== 1'b0 ||
            bus.OUT_TAG !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b p=%h pz=%b tag=%h required 0 0 0 0",
                     bus.OUT_VALID, bus.P, bus.P_ZERO, bus.OUT_TAG);
        end
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.IN_READY);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single();
        vec_t vecs[7];
        int lat;
        logic [63:0] p;
        logic pz;
        logic [7:0] t;
        vecs[0] = '{32'h1800_0000, 32'h1000_0000, 1'b0, 1'b0, 8'h11, 64'd32, 1'b0};
        vecs[1] = '{32'h0C00_0000, 32'h0C00_0000, 1'b0, 1'b0, 8'h22, 64'd8, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h33, 64'hFFFF_FFE0_0000_0000, 1'b0};
        vecs[3] = '{32'h1800_0000, 32'h1000_0000, 1'b1, 1'b0, 8'h44, 64'd0, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'h5A, 64'd1, 1'b0};
        vecs[5] = '{32'h0C00_0000, 32'h0000_0000, 1'b0, 1'b0, 8'h66, 64'd3, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 8'hFF, 64'd0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            send_one(vecs[i], lat, p, pz, t);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL single_latency[%0d]: got %0d required 3", i, lat);
            end
            checks++;
            if (p !== vecs[i].p || pz !== vecs[i].pz) begin
                errors++;
                $display("FAIL single_product[%0d]: got p=%h pz=%b required p=%h pz=%b",
                         i, p, pz, vecs[i].p, vecs[i].pz);
            end
            checks++;
            if (t !== vecs[i].tag) begin
                errors++;
                $display("FAIL single_tag[%0d]: got %h required %h", i, t, vecs[i].tag);
            end
        end
        drain();
    endtask

    // Four pairs on consecutive cycles must leave on four consecutive cycles.
    task automatic test_back_to_back();
        logic [4:0] kk;
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (c >= 3 && c <= 6) begin
                if (bus.OUT_VALID !== 1'b1 || bus.OUT_TAG !== 8'(8'h20 + c - 3) ||
                    bus.P !== (64'd1 << (c - 2))) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b tag=%h p=%h required v=1 tag=%h p=%h",
                             c, bus.OUT_VALID, bus.OUT_TAG, bus.P, 8'(8'h20 + c - 3),
                             64'd1 << (c - 2));
                end
            end else if (bus.OUT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL b2b_bubble[%0d]: got v=%b required 0", c, bus.OUT_VALID);
            end
            if (c < 4) begin
                kk = 5'(c + 1);
                bus.A = {kk, 27'd0};
                bus.B = 32'd0;
                bus.IN_TAG = 8'(8'h20 + c);
                bus.IN_VALID = 1'b1;
            end else begin
                bus.IN_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        drain();
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic in_xfer, out_xfer, exp_rdy;
        logic hold_valid = 1'b0;
        logic [63:0] hold_p = '0;
        logic hold_pz = 1'b0;
        logic [7:0] hold_tag = '0;
        logic [4:0] kk;
        logic [wl_T+wl_P-1:0] exp_item;
        exp_q.delete();
        while (got < 10 && cyc < 500) begin
            bus.OUT_READY = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                kk = 5'(sent);
                bus.A = {kk, 27'd0};
                bus.B = 32'h0800_0000;
                bus.A_ZERO = 1'b0;
                bus.B_ZERO = 1'b0;
                bus.IN_TAG = 8'(sent);
                bus.IN_VALID = 1'b1;
            end else begin
                bus.IN_VALID = 1'b0;
            end
            #1;
            exp_rdy = !(bus.OUT_VALID && !bus.OUT_READY);
            checks++;
            if (bus.IN_READY !== exp_rdy) begin
                errors++;
                $display("FAIL stream_in_ready[cyc %0d]: got %b required %b",
                         cyc, bus.IN_READY, exp_rdy);
            end
            if (hold_valid) begin
                checks++;
                if (bus.OUT_VALID !== 1'b1 || bus.P !== hold_p || bus.P_ZERO !== hold_pz ||
                    bus.OUT_TAG !== hold_tag) begin
                    errors++;
                    $display("FAIL stream_stall_hold[cyc %0d]: got v=%b p=%h tag=%h required v=1 p=%h tag=%h",
                             cyc, bus.OUT_VALID, bus.P, bus.OUT_TAG, hold_p, hold_tag);
                end
            end
            in_xfer = bus.IN_VALID && bus.IN_READY;
            out_xfer = bus.OUT_VALID && bus.OUT_READY;
            if (out_xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_output: got tag=%h p=%h required none",
                             bus.OUT_TAG, bus.P);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({bus.OUT_TAG, bus.P} !== exp_item || bus.P_ZERO !== 1'b0) begin
                        errors++;
                        $display("FAIL stream_output[%0d]: got tag=%h p=%h pz=%b required tag=%h p=%h pz=0",
                                 got, bus.OUT_TAG, bus.P, bus.P_ZERO,
                                 exp_item[wl_P +: wl_T], exp_item[wl_P-1:0]);
                    end
                end
                got++;
            end
            hold_valid = bus.OUT_VALID && !bus.OUT_READY;
            hold_p = bus.P;
            hold_pz = bus.P_ZERO;
            hold_tag = bus.OUT_TAG;
            @(posedge CLK);
            if (in_xfer) begin
                exp_q.push_back({8'(sent), 64'd1 << (sent + 1)});
                sent++;
            end
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (got !== 10 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs (%0d pending) required 10 (0 pending)",
                     got, exp_q.size());
        end
        drain();
    endtask

    task automatic test_reset_in_flight();
        logic [4:0] kk;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            kk = 5'(i + 2);
            bus.A = {kk, 27'd0};
            bus.B = 32'd0;
            bus.IN_TAG = 8'(8'hA0 + i);
            bus.IN_VALID = 1'b1;
            @(negedge CLK);
        end
        idle_inputs();
        bus.OUT_READY = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_TAG !== 8'hA0) begin
            errors++;
            $display("FAIL rst_pre_full: got v=%b tag=%h required v=1 tag=a0",
                     bus.OUT_VALID, bus.OUT_TAG);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL rst_async_drop: got v=%b in_ready=%b required v=0 in_ready=1",
                     bus.OUT_VALID, bus.IN_READY);
        end
        @(negedge CLK);
        RST = 1'b0;
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (c == 3) begin
                if (bus.OUT_VALID !== 1'b1 || bus.OUT_TAG !== 8'h55 || bus.P !== 64'd32) begin
                    errors++;
                    $display("FAIL rst_after_release: got v=%b tag=%h p=%h required v=1 tag=55 p=20",
                             bus.OUT_VALID, bus.OUT_TAG, bus.P);
                end
            end else if (bus.OUT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale_output[%0d]: got v=1 tag=%h required v=0",
                         c, bus.OUT_TAG);
            end
            if (c == 0) begin
                bus.A = 32'h1800_0000;
                bus.B = 32'h1000_0000;
                bus.IN_TAG = 8'h55;
                bus.IN_VALID = 1'b1;
            end else begin
                bus.IN_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
